popcount_sequencer: RTL and testbench
=====================================

# popcount_sequencer

Multi-cycle bit-population counter with valid/ready handshakes on both sides. It accepts a WIDTH-bit word and scans it CHUNK bits per cycle, accumulating the number of bits equal to a requested match value (1 or 0). It returns the total on a held result port. This is the synthesizable, resource-shared counterpart of the `$countones`/`$countbits` checks used in our assertion benches: one small CHUNK-wide adder is time-multiplexed across the word instead of a full WIDTH-wide adder tree.

## Interface

Parameters:

- `WIDTH`, default 16: input word width. Must be a multiple of `CHUNK`; ≥ `CHUNK`.
- `CHUNK`, default 4: bits counted per scan cycle. `NCHUNK = WIDTH/CHUNK`.

Ports:

- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: request present.
- `in_ready`  out  1: block can accept; equals (state==IDLE) && !rst.
- `in_data`  in  WIDTH: word to count; sampled only on accept.
- `in_match`  in  1: 1 = count ones, 0 = count zeros; sampled only on accept.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes result.
- `out_count`  out  $clog2(WIDTH+1): number of matching bits.
- `busy`  out  1: high in SCAN and DONE.
- `out_onehot`, `out_onehot0`  out  1 each: present only with `POPCNT_ONEHOT_EN`.

## Operation

States are IDLE, SCAN and DONE.

- **IDLE:** `in_ready`=1. On `in_valid && in_ready`:
  - latch `word = in_match ? in_data : ~in_data`;
  - clear accumulator and chunk index `idx`;
  - go to SCAN.
- **SCAN:** each cycle:
  - `acc += countones(word[idx*CHUNK +: CHUNK])` (CHUNK-input popcount plus one adder);
  - `idx++`, starting at chunk 0 (LSBs).
  - When `idx == NCHUNK-1` is processed, go to DONE.
  - `in_valid` is ignored in SCAN.
- **DONE:** `out_valid`=1 and `out_count`=acc, both stable until `out_ready`. On `out_valid && out_ready`, go to IDLE.

Datapath and boundary rules:

- **Accumulator width:** $clog2(WIDTH+1), so the all-match result (WIDTH) never wraps. Example: WIDTH=16 gives 5 bits, max 16.
- **Chunk index width:** $clog2(NCHUNK), minimum 1. When NCHUNK=1, SCAN lasts exactly one cycle.
- **No overlap:** a new request is never accepted in the same cycle a result is consumed. IDLE is always visited for at least one cycle.
- **Input stability:** `in_data` and `in_match` changing after accept have no effect.

## Timing

- **Reset values** (register state after a `rst`-high edge): state=IDLE, `out_valid`=0, `out_count`=0, `busy`=0, `out_onehot`=0, `out_onehot0`=0. `in_ready` is 0 while `rst` is high and 1 in the first cycle after.
- **Reset mid-operation:** `rst` in SCAN or DONE aborts and discards the result. No `out_valid` pulse appears for that request.
- **Accept:** request accepted at edge T0.
  - Scan edges are T0+1 … T0+NCHUNK.
  - `out_valid` rises after edge T0+NCHUNK.
  - Latency from accept to `out_valid` is NCHUNK cycles.
- **Consume:** with `out_ready` already high, the result is consumed at edge T0+NCHUNK+1. IDLE follows, and the next accept is at T0+NCHUNK+2 at the earliest.
  - Peak throughput: one word per NCHUNK+2 cycles.
- **Backpressure:** `out_ready` low holds DONE indefinitely. `out_count` is unchanged and `in_ready`=0 throughout.
- **`busy`:** rises the cycle after accept and falls the cycle after consume.

## Configuration

- **`POPCNT_ONEHOT_EN` defined:**
  - Adds registered outputs `out_onehot` = (result==1) and `out_onehot0` = (result<=1).
  - Both are computed from the final accumulator and become valid together with `out_valid`.
  - Same hold and reset rules as `out_count`.
  - Adds no latency.
- **`POPCNT_ONEHOT_EN` undefined:** the ports and logic are absent.

## Test plan

WIDTH=16, CHUNK=4 unless noted.

1. `in_data`=16'h0001, `in_match`=1, accept at T0 -> `out_valid` after edge T0+4, `out_count`=1, `busy` high for 5 cycles with `out_ready`=1.
2. `in_data`=16'hFFFF with `in_match`=1, then `in_match`=0 -> `out_count`=16 (no wrap), then 0; next `in_ready` is 0 until IDLE is re-entered.
3. `in_data`=16'h00F0, `in_match`=0; change `in_data` to 16'h0000 one cycle after accept -> `out_count`=12.
4. `in_data`=16'hA5A5, `in_match`=1, `out_ready` low for 10 cycles after `out_valid` -> `out_count`=8 held stable, `in_valid` pulses ignored, consumed on the first `out_ready` edge.
5. `rst` asserted for one cycle during the second SCAN cycle -> no `out_valid`. All outputs at reset values, `in_ready`=1 the next cycle; a fresh 16'h0003 request then yields 2.
6. With `POPCNT_ONEHOT_EN`:
   - 16'h0100, match=1 -> `out_onehot`=1, `out_onehot0`=1.
   - 16'h0000, match=1 -> `out_onehot`=0, `out_onehot0`=1.
   - 16'h0300, match=1 -> both 0.
   - Repeat case 1 with WIDTH=4, CHUNK=4 -> latency 1.

Source files
------------

// File: rtl/popcount_sequencer.sv
// popcount_sequencer: counts bits equal to in_match over a WIDTH-bit word, CHUNK bits per cycle, with valid/ready on both sides.
// Define POPCNT_ONEHOT_EN to add registered out_onehot/out_onehot0 result flags.
module popcount_sequencer #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_match,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       busy
`ifdef POPCNT_ONEHOT_EN
  ,
  output logic                       out_onehot,
  output logic                       out_onehot0
`endif
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] word;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0] cnt, sum;
  logic last;
  assign in_ready = state == IDLE && !rst;
  assign chunk = word[idx*CHUNK +: CHUNK];
  assign last = idx == IW'(NCHUNK - 1);
  // out_count doubles as the accumulator; only its DONE value is meaningful
  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) cnt = cnt + CW'(chunk[i]);
    sum = out_count + cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      busy      <= 1'b0;
`ifdef POPCNT_ONEHOT_EN
      out_onehot  <= 1'b0;
      out_onehot0 <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (in_valid) begin
        state     <= SCAN;
        word      <= in_match ? in_data : ~in_data;
        idx       <= '0;
        out_count <= '0;
        busy      <= 1'b1;
`ifdef POPCNT_ONEHOT_EN
        out_onehot  <= 1'b0;
        out_onehot0 <= 1'b0;
`endif
      end
    end else if (state == SCAN) begin
      out_count <= sum;
      idx       <= last ? '0 : idx + 1'b1;
      if (last) begin
        state     <= DONE;
        out_valid <= 1'b1;
`ifdef POPCNT_ONEHOT_EN
        out_onehot  <= sum == CW'(1);
        out_onehot0 <= sum <= CW'(1);
`endif
      end
    end else if (out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_popcount_sequencer.sv
// tb_popcount_sequencer: table vectors, random requests against a bit-counting model, reset and single-chunk corner cases.
module tb_popcount_sequencer;
  localparam int W = 16, C = 4, N = W / C, CW = $clog2(W + 1);
  logic clk = 0, rst = 1, in_valid = 0, in_match = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] in_data = '0;
  logic [CW-1:0] out_count;
`ifdef POPCNT_ONEHOT_EN
  logic out_onehot, out_onehot0;
`endif
  logic s_valid = 0, s_match = 0, s_oready = 0, s_ready, s_ovalid, s_busy;
  logic [3:0] s_data = '0;
  logic [2:0] s_count;
`ifdef POPCNT_ONEHOT_EN
  logic s_oh, s_oh0;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  popcount_sequencer #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_match(in_match), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .busy(busy)
`ifdef POPCNT_ONEHOT_EN
    , .out_onehot(out_onehot), .out_onehot0(out_onehot0)
`endif
  );
  popcount_sequencer #(.WIDTH(4), .CHUNK(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data),
    .in_match(s_match), .out_valid(s_ovalid), .out_ready(s_oready), .out_count(s_count), .busy(s_busy)
`ifdef POPCNT_ONEHOT_EN
    , .out_onehot(s_oh), .out_onehot0(s_oh0)
`endif
  );
  typedef struct {
    logic [W-1:0] d;
    logic         m;
    int           hold;
    int           exp;
  } vec_t;
  vec_t tbl[9] = '{
    '{16'h0001, 1'b1, 0, 1},
    '{16'hFFFF, 1'b1, 0, 16},
    '{16'hFFFF, 1'b0, 0, 0},
    '{16'h00F0, 1'b0, 0, 12},
    '{16'hA5A5, 1'b1, 10, 8},
    '{16'h0100, 1'b1, 0, 1},
    '{16'h0000, 1'b1, 2, 0},
    '{16'h0300, 1'b1, 0, 2},
    '{16'h8000, 1'b0, 1, 15}
  };
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int ref_count(input logic [W-1:0] d, input logic m);
    int n = 0;
    for (int i = 0; i < W; i++) if (d[i] == m) n++;
    return n;
  endfunction
  task automatic run_req(input logic [W-1:0] d, input logic m, input int hold, input int exp, input string name);
    int k = 0;
    int b = 0;
    while (!in_ready && k < 50) begin
      tick;
      k++;
    end
    chk({name, " in_ready"}, in_ready, 1);
    in_valid = 1;
    in_data = d;
    in_match = m;
    tick;
    in_valid = 0;
    in_data = W'($urandom);
    in_match = 1'($urandom);
    chk({name, " in_ready busy"}, in_ready, 0);
    k = 0;
    while (!out_valid && k < 50) begin
      b += int'(busy);
      tick;
      k++;
    end
    chk({name, " latency"}, k, N);
    chk({name, " count"}, out_count, exp);
`ifdef POPCNT_ONEHOT_EN
    chk({name, " onehot"}, out_onehot, exp == 1);
    chk({name, " onehot0"}, out_onehot0, exp <= 1);
`endif
    for (int i = 0; i < hold; i++) begin
      b += int'(busy);
      in_valid = 1'($urandom);
      tick;
      chk({name, " held valid"}, out_valid, 1);
      chk({name, " held count"}, out_count, exp);
      chk({name, " held in_ready"}, in_ready, 0);
    end
    b += int'(busy);
    in_valid = 1;
    out_ready = 1;
    tick;
    out_ready = 0;
    chk({name, " consumed"}, out_valid, 0);
    chk({name, " no overlap"}, busy, 0);
    chk({name, " idle ready"}, in_ready, 1);
    in_valid = 0;
    chk({name, " busy cycles"}, b, N + 1 + hold);
  endtask
  initial begin
    tick;
    tick;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset count", out_count, 0);
`ifdef POPCNT_ONEHOT_EN
    chk("reset onehot", {out_onehot, out_onehot0}, 0);
`endif
    rst = 0;
    #1;
    chk("post reset in_ready", in_ready, 1);
    foreach (tbl[i]) run_req(tbl[i].d, tbl[i].m, tbl[i].hold, tbl[i].exp, $sformatf("vec%0d", i));
    // abort a request during its second scan cycle
    in_valid = 1;
    in_data = 16'h00FF;
    in_match = 1;
    tick;
    in_valid = 0;
    tick;
    rst = 1;
    tick;
    chk("abort in_ready", in_ready, 0);
    chk("abort out_valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort count", out_count, 0);
    rst = 0;
    #1;
    chk("abort ready after", in_ready, 1);
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick;
        seen |= int'(out_valid);
      end
      chk("abort no result", seen, 0);
    end
    run_req(16'h0003, 1'b1, 0, 2, "after abort");
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d = W'($urandom);
      logic m = 1'($urandom);
      run_req(d, m, int'($urandom_range(0, 3)), ref_count(d, m), $sformatf("rand%0d", i));
    end
    s_valid = 1;
    s_data = 4'h1;
    s_match = 1;
    tick;
    s_valid = 0;
    s_data = 4'hF;
    chk("w4 scan", s_ovalid, 0);
    chk("w4 busy", s_busy, 1);
    tick;
    chk("w4 latency", s_ovalid, 1);
    chk("w4 count", s_count, 1);
`ifdef POPCNT_ONEHOT_EN
    chk("w4 onehot", {s_oh, s_oh0}, 3);
`endif
    s_oready = 1;
    tick;
    s_oready = 0;
    chk("w4 consumed", s_ovalid, 0);
    chk("w4 ready", s_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
